// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide engine for the multicycle MIPS core.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each
//   runs one bit per clock. A sign-fix phase follows, and the result is
//   then presented on hi/lo with a one-cycle done pulse. Every op takes
//   the same 34 edges from accept to done.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset
//   start_i        request, honoured only in IDLE with a valid op
//   op_i[6:0]      DIV=7, DIVU=8, MULT=13, MULTU=14, other values ignored
//   a_i, b_i       rs / rt operands, sampled on the accepting edge
//   busy_o         operation in progress
//   done_o         one-cycle pulse, hi/lo/div_by_zero valid with it
//   hi_o, lo_o     product high/low, or remainder/quotient
//   div_by_zero_o  last completed op was a divide with b == 0
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [6:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  div_by_zero_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 2);

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q;     // mul: {partial, multiplier}; div: {rem, quo}
  logic [W:0]      mag_q;     // multiplicand or divisor magnitude
  logic [W-1:0]    a_q;       // raw rs, returned in hi on divide by zero
  logic            sa_q, sb_q, div_q, dz_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            dzo_q;

  // ---------------------------------------------------------------- decode
  logic op_mul, op_div, op_signed, accept;
  assign op_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign op_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign accept    = (state_q == S_IDLE) && start_i && (op_mul || op_div);

  // Magnitudes are one bit wider so that -2^(W-1) negates without wrapping.
  logic       a_neg, b_neg;
  logic [W:0] a_mag, b_mag;
  assign a_neg = op_signed & a_i[W-1];
  assign b_neg = op_signed & b_i[W-1];
  assign a_mag = a_neg ? ((W+1)'(0) - {a_i[W-1], a_i}) : {1'b0, a_i};
  assign b_mag = b_neg ? ((W+1)'(0) - {b_i[W-1], b_i}) : {1'b0, b_i};

  // -------------------------------------------------------- iteration step
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] mul_next, div_next;
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + mag_q;
  assign mul_next  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - mag_q;
  // A clear top bit means no borrow, so the subtraction is kept and a 1 is
  // shifted into the quotient. A zero divisor always keeps it, which leaves
  // an all-ones quotient. The fix phase overrides that case anyway.
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

  // ------------------------------------------------------- sign correction
  logic [W-1:0]   rem, quo;
  logic [2*W-1:0] fix_val;
  assign rem = acc_q[2*W-1:W];
  assign quo = acc_q[W-1:0];
  always_comb begin
    fix_val = acc_q;
    if (!div_q)
      fix_val = (sa_q ^ sb_q) ? ((2*W)'(0) - acc_q) : acc_q;
    else if (dz_q)
      fix_val = {a_q, {W{1'b1}}};
    else
      fix_val = {(sa_q ? (W'(0) - rem) : rem), ((sa_q ^ sb_q) ? (W'(0) - quo) : quo)};
  end

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  // FIX lasts two edges. The first applies the sign correction and the
  // second publishes hi/lo, which gives the fixed 34-edge latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_div ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      S_FIX:  if (cnt_q == CW'(W + 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy_o = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    done_o = (state_q == S_DONE);
  end
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dzo_q;

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      acc_q <= '0;
      mag_q <= '0;
      a_q   <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      dzo_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          a_q   <= a_i;
          sa_q  <= a_neg;
          sb_q  <= b_neg;
          div_q <= op_div;
          dz_q  <= op_div && (b_i == '0);
          cnt_q <= '0;
          mag_q <= op_div ? b_mag : a_mag;
          acc_q <= {{W{1'b0}}, (op_div ? a_mag[W-1:0] : b_mag[W-1:0])};
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W)) begin
            acc_q <= fix_val;
          end else begin
            hi_q  <= acc_q[2*W-1:W];
            lo_q  <= acc_q[W-1:0];
            dzo_q <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide engine for the multicycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU one bit per cycle and presents 64-bit results as HI/LO words.
- Sits directly upstream of the ALU's HI/LO registers. The ALU stage stalls on busy and latches hi/lo on done.
- Replaces the single-cycle combinational multiplier/divider path.

Parameters:
- DATA_WIDTH, 32: operand width. Iteration count equals DATA_WIDTH. All test values below assume the default.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Accepted only in IDLE with a valid op.
- op  input  7  opcode in core encoding: DIV=7, DIVU=8, MULT=13, MULTU=14. Any other value is ignored.
- a  input  DATA_WIDTH  rs operand (multiplicand / dividend). Sampled on the accepting edge only.
- b  input  DATA_WIDTH  rt operand (multiplier / divisor). Sampled on the accepting edge only.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse. hi/lo and div_by_zero are valid while it is high.
- hi  output  DATA_WIDTH  product upper word / remainder.
- lo  output  DATA_WIDTH  product lower word / quotient.
- div_by_zero  output  1  last DIV/DIVU had b==0. Updated with done.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, internal regs cleared.
  - Reset mid-operation aborts with no done pulse. hi/lo return to 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - If start=1 and op is valid on a rising edge, latch a, b and op.
  - Store magnitudes |a| and |b| for signed ops; raw values for unsigned ops.
  - Record the sign flags, clear counter, then go to MUL (MULT/MULTU) or DIV (DIV/DIVU). busy=1 from that edge.
- MUL: shift-add, one bit per edge, for exactly DATA_WIDTH edges. Holds a 2*DATA_WIDTH accumulator.
- DIV: restoring division, one quotient bit per edge, for exactly DATA_WIDTH edges. Holds remainder and quotient registers.
- FIX: one edge of sign correction, then go to DONE.
  - Signed multiply: negate the 64-bit product (two's complement) if sign(a) != sign(b).
  - Signed divide: negate the quotient if sign(a) != sign(b). The remainder takes the sign of the dividend (truncating division).
  - Unsigned ops pass through unchanged.
- DONE:
  - On entering DONE, hi/lo/div_by_zero are registered and done=1, busy=0, for exactly one cycle.
  - Next edge returns to IDLE with done=0.
- Latency: accepting edge E0. Iterations occupy E1..E32, FIX is E33, done rises after E34. Fixed 34 edges for every op, including divide-by-zero.
- busy is high from after E0 until done rises. busy and done are never high together.
- start while busy, done, or with an invalid op: ignored. No queuing.
- start in the DONE cycle is ignored. A new op can be accepted on the edge after done.
- hi/lo hold the last result until the next done. They never show intermediate values.
- Divide by zero (DIV or DIVU, b==0):
  - Runs the full latency.
  - Result: lo=32'hFFFF_FFFF, hi=a (original operand, unsigned and signed alike), div_by_zero=1.
  - div_by_zero=0 after any other completed op.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No trap, no flag.
- Magnitude of 0x8000_0000 is 2^31, held in DATA_WIDTH+1 bits internally so no overflow occurs.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF, start 1 cycle -> busy 34 cycles, then done pulse with hi=FFFFFFFE lo=00000001, div_by_zero=0.
- MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB. Then MULT 80000000*80000000 -> hi=40000000 lo=00000000.
- DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF. DIVU a=00000064 b=00000007 -> lo=0000000E hi=00000002.
- DIVU a=12345678 b=0 -> lo=FFFFFFFF hi=12345678 div_by_zero=1. Next MULTU 2*3 -> hi=0 lo=6 div_by_zero=0.
- DIV 80000000/FFFFFFFF -> lo=80000000 hi=00000000.
- During a MULT, pulse start with DIVU (new operands) at cycle 10 -> ignored, original result only. Start with op=5 in IDLE -> busy stays 0.
- After a completed op, assert reset asynchronously mid-cycle at iteration 20 of a DIV -> busy, done, hi, lo drop to 0 immediately, no done pulse. A fresh op after release completes normally.
